// File: rtl/piano_key_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piano_key_controller: sync/debounce/stretch seven keys for display, and
// arbitrate them to one note sent to the tone generator over req/ack.
// Revision: 1.0
// ----------------------------------------------------------------------------
module piano_key_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MIN_HOLD_FRAMES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] key_in,
  input  logic       frame_start,
  output logic [6:0] note_disp,
  output logic       tone_req,
  output logic [2:0] tone_note,
  output logic       tone_on,
  input  logic       tone_ack
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(MIN_HOLD_FRAMES + 1);
  localparam logic [CW-1:0] c_deb_last  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] c_hold_init = HW'(MIN_HOLD_FRAMES);
  localparam logic [0:0]    c_st_idle   = 1'b0;
  localparam logic [0:0]    c_st_send   = 1'b1;

  logic [6:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [6:0]    deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q [7];
  logic [CW-1:0] cnt_d [7];
  logic [6:0]    pend_q, pend_d, disp_q, disp_d;
  logic [HW-1:0] hold_q [7];
  logic [HW-1:0] hold_d [7];
  logic [2:0]    cur_q, cur_d;
  logic          tgt_on_q, tgt_on_d;
  logic [0:0]    state_q, state_d;
  logic          req_q, req_d, on_q, on_d, sent_on_q, sent_on_d;
  logic [2:0]    note_q, note_d, sent_note_q, sent_note_d;

  logic [6:0]    deb_rise, deb_fall;
  logic          tgt_change;

  function automatic logic [2:0] lowest(input logic [6:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign deb_rise   = deb_q & ~deb_prev_q;
  assign deb_fall   = ~deb_q & deb_prev_q;
  assign tgt_change = (tgt_on_q != sent_on_q) || (tgt_on_q && (cur_q != sent_note_q));

  // Any mismatch between synced and debounced level advances the count; a
  // bounce back to the debounced level restarts it.
  always_comb begin
    sync1_d    = key_in;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == c_deb_last) deb_d[i] = sync2_q[i];
        else                        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    pend_d = deb_rise | (pend_q & ~{7{frame_start}});
    disp_d = disp_q;
    for (int i = 0; i < 7; i++) begin
      hold_d[i] = hold_q[i];
      if (frame_start) begin
        if (deb_q[i] || pend_q[i]) begin
          disp_d[i] = 1'b1;
          hold_d[i] = c_hold_init;
        end else if (hold_q[i] > HW'(1)) begin
          hold_d[i] = hold_q[i] - HW'(1);
        end else begin
          hold_d[i] = '0;
          disp_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cur_d    = cur_q;
    tgt_on_d = tgt_on_q;
    if (|deb_rise) begin
      cur_d    = lowest(deb_rise);
      tgt_on_d = 1'b1;
    end else if (deb_fall[cur_q]) begin
      if (|deb_q) cur_d    = lowest(deb_q);
      else        tgt_on_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == c_st_idle) begin
      if (tgt_change) state_d = c_st_send;
    end else begin
      if (tone_ack) state_d = c_st_idle;
    end
  end

  always_comb begin
    req_d       = req_q;
    note_d      = note_q;
    on_d        = on_q;
    sent_note_d = sent_note_q;
    sent_on_d   = sent_on_q;
    if (state_q == c_st_idle) begin
      if (tgt_change) begin
        note_d = cur_q;
        on_d   = tgt_on_q;
        req_d  = 1'b1;
      end
    end else if (tone_ack) begin
      sent_note_d = note_q;
      sent_on_d   = on_q;
      req_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      pend_q      <= '0;
      disp_q      <= '0;
      cur_q       <= '0;
      tgt_on_q    <= 1'b0;
      state_q     <= c_st_idle;
      req_q       <= 1'b0;
      note_q      <= '0;
      on_q        <= 1'b0;
      sent_note_q <= '0;
      sent_on_q   <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      tgt_on_q    <= tgt_on_d;
      state_q     <= state_d;
      req_q       <= req_d;
      note_q      <= note_d;
      on_q        <= on_d;
      sent_note_q <= sent_note_d;
      sent_on_q   <= sent_on_d;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign note_disp = disp_q;
  assign tone_req  = req_q;
  assign tone_note = note_q;
  assign tone_on   = on_q;

endmodule
`default_nettype wire

// File: tb/tb_piano_key_controller.sv
`default_nettype none
// Bench for piano_key_controller: per-cycle comparison against a behavioural
// model, directed scenarios with literal expectations, then random keys/frames.
module tb_piano_key_controller;

  localparam int D = 16;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       reset, frame_start, man_ack, auto_ack, auto_pulse;
  logic [6:0] key_in;
  logic [6:0] note_disp;
  logic       tone_req, tone_on, tone_ack;
  logic [2:0] tone_note;

  assign tone_ack = auto_ack ? auto_pulse : man_ack;

  piano_key_controller #(.DEBOUNCE_CYCLES(D), .MIN_HOLD_FRAMES(H)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .frame_start(frame_start),
    .note_disp(note_disp), .tone_req(tone_req), .tone_note(tone_note),
    .tone_on(tone_on), .tone_ack(tone_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model state
  logic [6:0] m_s1, m_s2, m_deb, m_prev, m_pend, m_disp;
  int         m_run [7];
  int         m_hold [7];
  logic [2:0] m_cur, m_note, m_snote;
  logic       m_tgt, m_req, m_on, m_son;
  logic [3:0] log_q [$];

  function automatic logic [2:0] low_idx(input logic [6:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 6; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    logic [6:0] rise, fall;
    if (!reset && tone_req && tone_ack) log_q.push_back({tone_note, tone_on});
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_prev = 0; m_pend = 0; m_disp = 0;
      m_cur = 0; m_note = 0; m_snote = 0; m_tgt = 0; m_req = 0; m_on = 0; m_son = 0;
      for (int i = 0; i < 7; i++) begin m_run[i] = 0; m_hold[i] = 0; end
    end else begin
      if (!m_req) begin
        if ((m_tgt != m_son) || (m_tgt && m_cur != m_snote)) begin
          m_req = 1; m_note = m_cur; m_on = m_tgt;
        end
      end else if (tone_ack) begin
        m_snote = m_note; m_son = m_on; m_req = 0;
      end
      rise = m_deb & ~m_prev;
      fall = ~m_deb & m_prev;
      if (rise != 0) begin
        m_cur = low_idx(rise); m_tgt = 1;
      end else if (fall[m_cur]) begin
        if (m_deb != 0) m_cur = low_idx(m_deb);
        else            m_tgt = 0;
      end
      if (frame_start) begin
        for (int i = 0; i < 7; i++) begin
          if (m_deb[i] || m_pend[i]) begin m_disp[i] = 1; m_hold[i] = H; end
          else if (m_hold[i] > 1) m_hold[i]--;
          else begin m_hold[i] = 0; m_disp[i] = 0; end
        end
      end
      m_pend = rise | (frame_start ? 7'd0 : m_pend);
      m_prev = m_deb;
      for (int i = 0; i < 7; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = key_in;
    end
    #1;
    chk("cycle", 32'({note_disp, tone_req, tone_note, tone_on}),
                 32'({m_disp, m_req, m_note, m_on}));
  end

  // Auto-acknowledge responder with programmable delay
  int ack_dly = 2;
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (auto_pulse) auto_pulse = 1'b0;
    else if (tone_req) begin
      if (ack_cnt >= ack_dly) begin auto_pulse = 1'b1; ack_cnt = 0; end
      else ack_cnt++;
    end else ack_cnt = 0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    log_q.delete();
  endtask

  task automatic chk_log(input string nm, input int n, input logic [15:0] e);
    chk({nm, "_len"}, 32'(log_q.size()), 32'(n));
    for (int k = 0; k < n && k < log_q.size(); k++)
      chk(nm, 32'(log_q[k]), 32'(e[15-4*k -: 4]));
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; man_ack = 1'b0; auto_ack = 1'b0;
    auto_pulse = 1'b0; key_in = '0;
    cyc(3);
    chk("reset_outputs", 32'({note_disp, tone_req, tone_note, tone_on}), 32'(0));
    reset = 1'b0;

    // Bouncing key E then held: request exactly D+4 edges after last toggle
    cyc(2);
    key_in[2] = 1'b1; cyc(3);
    key_in[2] = 1'b0; cyc(3);
    key_in[2] = 1'b1;
    repeat (19) @(posedge clk);
    #1 chk("t1_no_req_edge19", 32'(tone_req), 32'(0));
    @(posedge clk);
    #1 chk("t1_req_edge20", 32'({tone_req, tone_note, tone_on}), 32'(5'b1_010_1));
    cyc(3);
    man_ack = 1'b1;
    @(posedge clk);
    #1 chk("t1_req_drop", 32'(tone_req), 32'(0));
    @(negedge clk) man_ack = 1'b0;
    key_in = '0;

    // Short tap between frames is stretched across H frames
    do_reset();
    auto_ack = 1'b1; ack_dly = 2;
    frame();
    key_in[0] = 1'b1; cyc(40);
    key_in[0] = 1'b0; cyc(50);
    frame(); chk("t2_frame1", 32'(note_disp[0]), 32'(1));
    cyc(20); chk("t2_gap1", 32'(note_disp[0]), 32'(1));
    frame(); chk("t2_frame2", 32'(note_disp[0]), 32'(1));
    cyc(20); chk("t2_gap2", 32'(note_disp[0]), 32'(1));
    frame(); chk("t2_frame3", 32'(note_disp[0]), 32'(1));
    cyc(20); chk("t2_gap3", 32'(note_disp[0]), 32'(1));
    frame(); chk("t2_frame4", 32'(note_disp[0]), 32'(0));

    // Hold C, press G, release G, release C
    do_reset();
    key_in = 7'b0000001; cyc(40);
    key_in = 7'b0010001; cyc(40);
    key_in = 7'b0000001; cyc(40);
    key_in = 7'b0000000; cyc(40);
    chk_log("t3_log", 4, 16'h1910);

    // Withheld ack while keys step C->D->E: D coalesced away
    do_reset();
    auto_ack = 1'b0;
    key_in = 7'b0000001; cyc(25);
    chk("t4_first_req", 32'({tone_req, tone_note, tone_on}), 32'(5'b1_000_1));
    key_in = 7'b0000010; cyc(25);
    key_in = 7'b0000100; cyc(30);
    chk("t4_held_req", 32'({tone_req, tone_note, tone_on}), 32'(5'b1_000_1));
    @(negedge clk) man_ack = 1'b1;
    @(posedge clk);
    #1 chk("t4_low_cycle", 32'(tone_req), 32'(0));
    @(negedge clk) man_ack = 1'b0;
    @(posedge clk);
    #1 chk("t4_second_req", 32'({tone_req, tone_note, tone_on}), 32'(5'b1_010_1));
    @(negedge clk) man_ack = 1'b1;
    @(negedge clk) man_ack = 1'b0;
    chk_log("t4_log", 2, 16'h1500);
    key_in = '0;

    // Simultaneous D+A rise picks D; releasing D moves to A
    do_reset();
    auto_ack = 1'b1;
    key_in = 7'b0100010; cyc(30);
    chk("t5_note_d", 32'(tone_note), 32'(1));
    key_in = 7'b0100000; cyc(40);
    chk_log("t5_log", 2, 16'h3B00);
    key_in = '0;

    // Reset during SEND with C held
    do_reset();
    auto_ack = 1'b0;
    key_in = 7'b0000001; cyc(25);
    chk("t6_in_send", 32'(tone_req), 32'(1));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("t6_reset_edge", 32'({note_disp, tone_req, tone_note, tone_on}), 32'(0));
    @(negedge clk) reset = 1'b0;
    repeat (19) @(posedge clk);
    #1 chk("t6_no_req_edge19", 32'(tone_req), 32'(0));
    @(posedge clk);
    #1 chk("t6_req_edge20", 32'({tone_req, tone_note, tone_on}), 32'(5'b1_000_1));

    // Random keys, bounces, frames, ack delays and occasional resets
    auto_ack = 1'b1;
    key_in = '0;
    for (int it = 0; it < 150; it++) begin
      int  dur;
      logic rst_now;
      rst_now = ($urandom_range(0, 49) == 0);
      ack_dly = $urandom_range(0, 4);
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(17, 60);
      if ($urandom_range(0, 5) == 0) key_in = 7'($urandom_range(0, 127));
      else key_in = key_in ^ 7'(1 << $urandom_range(0, 6));
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        reset = rst_now && (c == 0);
        frame_start = ($urandom_range(0, 24) == 0);
      end
    end
    @(negedge clk) begin reset = 1'b0; frame_start = 1'b0; end
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
